patp_cycle_sequencer: RTL and testbench

//  Parametrised instruction-cycle sequencer for the PATP core; generalises the two-phase fetch/execute flag.

---
 rtl/patp_seq_pkg.sv | 22 ++
 rtl/patp_phase_counter.sv | 50 +++++
 rtl/patp_cycle_sequencer.sv | 131 +++++++++++++
 tb/tb_patp_cycle_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/patp_seq_pkg.sv
// Shared types and constants for the PATP instruction-cycle sequencer.
package patp_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_HALTED = 2'd0,
    SEQ_RUN    = 2'd1,
    SEQ_DRAIN  = 2'd2,
    SEQ_STEP   = 2'd3
  } seq_state_e;

  localparam int PH_FETCH   = 0;
  localparam int PH_EXEC    = 1;
  localparam int MAX_PHASES = 8;

  // Encoded phase width; never below one bit so a 2-phase core still has a phase bit.
  function automatic int phase_w(input int num_phases);
    int n;
    n = (num_phases > MAX_PHASES) ? MAX_PHASES : num_phases;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/patp_phase_counter.sv
// Modulo-NUM_PHASES phase counter with clear/advance, encoded and one-hot outputs.
module patp_phase_counter
  import patp_seq_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  localparam int PHASE_W = phase_w(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  clear,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_onehot,
  output logic                  wrap
);

  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [NUM_PHASES-1:0] onehot_q, onehot_d;
  logic                  at_last;

  assign at_last = (phase_q == PHASE_W'(NUM_PHASES - 1));

  always_comb begin
    phase_d  = phase_q;
    onehot_d = onehot_q;
    if (clear) begin
      phase_d  = PHASE_W'(PH_FETCH);
      onehot_d = NUM_PHASES'(1);
    end else if (advance) begin
      phase_d  = at_last ? PHASE_W'(PH_FETCH) : phase_q + PHASE_W'(1);
      onehot_d = {onehot_q[NUM_PHASES-2:0], onehot_q[NUM_PHASES-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PHASE_W'(PH_FETCH);
      onehot_q <= NUM_PHASES'(1);
    end else begin
      phase_q  <= phase_d;
      onehot_q <= onehot_d;
    end
  end

  assign phase        = phase_q;
  assign phase_onehot = onehot_q;
  // Flags that the current phase is the last one: the next advance retires.
  assign wrap         = at_last;

endmodule

// File: rtl/patp_cycle_sequencer.sv
// PATP instruction-cycle sequencer: run/halt/drain FSM, retire pulses and counter.
// Optional single-step mode is built when PATP_SEQ_STEP_EN is defined.
//
// state      | meaning
// SEQ_HALTED | idle, phase held at fetch, phase_done ignored
// SEQ_RUN    | executing instructions back to back
// SEQ_DRAIN  | finishing the current instruction, then halt
// SEQ_STEP   | executing exactly one instruction, then halt
module patp_cycle_sequencer
  import patp_seq_pkg::*;
#(
  parameter int NUM_PHASES    = 2,
  parameter int CNT_W         = 16,
  parameter bit START_RUNNING = 1'b0,
  localparam int PHASE_W = phase_w(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_req,
  input  logic                  halt_req,
`ifdef PATP_SEQ_STEP_EN
  input  logic                  step_req,
`endif
  input  logic                  phase_done,
  input  logic                  flush,
  output logic                  running,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_onehot,
  output logic                  instr_start,
  output logic                  instr_retire,
  output logic [CNT_W-1:0]      instr_count
);

  seq_state_e       state_q, state_d;
  logic             running_q, running_d;
  logic             start_q, start_d;
  logic             retire_q, retire_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             advance, clear, at_last, at_fetch, step_go;

  patp_phase_counter #(.NUM_PHASES(NUM_PHASES)) u_phase (
    .clk          (clk),
    .rst          (rst),
    .advance      (advance),
    .clear        (clear),
    .phase        (phase),
    .phase_onehot (phase_onehot),
    .wrap         (at_last)
  );

  assign at_fetch = (phase == PHASE_W'(PH_FETCH));

  always_comb begin
    step_go = 1'b0;
`ifdef PATP_SEQ_STEP_EN
    step_go = step_req;
`endif
  end

  always_comb begin
    state_d  = state_q;
    advance  = 1'b0;
    clear    = 1'b0;
    start_d  = 1'b0;
    retire_d = 1'b0;
    count_d  = count_q;
    unique case (state_q)
      SEQ_HALTED: begin
        if (!flush && !halt_req) begin
          if (run_req) begin
            state_d = SEQ_RUN;
            start_d = 1'b1;
          end else if (step_go) begin
            state_d = SEQ_STEP;
            start_d = 1'b1;
          end
        end
      end
      SEQ_RUN: begin
        if (flush) begin
          clear   = 1'b1;
          start_d = 1'b1;
        end else if (halt_req && at_fetch) begin
          state_d = SEQ_HALTED;
        end else begin
          advance = phase_done;
          if (halt_req) state_d = SEQ_DRAIN;
        end
      end
      default: begin
        if (flush) begin
          clear   = 1'b1;
          state_d = SEQ_HALTED;
        end else begin
          advance = phase_done;
          if (run_req && !halt_req) state_d = SEQ_RUN;
        end
      end
    endcase
    // Retire: only an instruction that continues in RUN gets a fresh start pulse.
    if (advance && at_last) begin
      retire_d = 1'b1;
      count_d  = count_q + CNT_W'(1);
      if (state_d == SEQ_RUN) start_d = 1'b1;
      else                    state_d = SEQ_HALTED;
    end
    running_d = (state_d != SEQ_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= START_RUNNING ? SEQ_RUN : SEQ_HALTED;
      running_q <= START_RUNNING;
      start_q   <= START_RUNNING;
      retire_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      start_q   <= start_d;
      retire_q  <= retire_d;
      count_q   <= count_d;
    end
  end

  assign running      = running_q;
  assign instr_start  = start_q;
  assign instr_retire = retire_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_patp_cycle_sequencer.sv
// Bench for patp_cycle_sequencer: three configurations checked every cycle against a behavioural model.
module tb_patp_cycle_sequencer;

  localparam int M_HALT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_STEP  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, run_req, halt_req, phase_done, flush;
`ifdef PATP_SEQ_STEP_EN
  logic [2:0] step_req;
`endif

  logic        run0, st0, rt0;
  logic [0:0]  ph0;
  logic [1:0]  oh0;
  logic [15:0] cnt0;
  logic        run1, st1, rt1;
  logic [1:0]  ph1;
  logic [3:0]  oh1;
  logic [3:0]  cnt1;
  logic        run2, st2, rt2;
  logic [1:0]  ph2;
  logic [2:0]  oh2;
  logic [7:0]  cnt2;

  patp_cycle_sequencer #(.NUM_PHASES(2), .CNT_W(16), .START_RUNNING(1'b0)) u0 (
    .clk(clk), .rst(rst[0]), .run_req(run_req[0]), .halt_req(halt_req[0]),
`ifdef PATP_SEQ_STEP_EN
    .step_req(step_req[0]),
`endif
    .phase_done(phase_done[0]), .flush(flush[0]), .running(run0), .phase(ph0),
    .phase_onehot(oh0), .instr_start(st0), .instr_retire(rt0), .instr_count(cnt0));

  patp_cycle_sequencer #(.NUM_PHASES(4), .CNT_W(4), .START_RUNNING(1'b0)) u1 (
    .clk(clk), .rst(rst[1]), .run_req(run_req[1]), .halt_req(halt_req[1]),
`ifdef PATP_SEQ_STEP_EN
    .step_req(step_req[1]),
`endif
    .phase_done(phase_done[1]), .flush(flush[1]), .running(run1), .phase(ph1),
    .phase_onehot(oh1), .instr_start(st1), .instr_retire(rt1), .instr_count(cnt1));

  patp_cycle_sequencer #(.NUM_PHASES(3), .CNT_W(8), .START_RUNNING(1'b1)) u2 (
    .clk(clk), .rst(rst[2]), .run_req(run_req[2]), .halt_req(halt_req[2]),
`ifdef PATP_SEQ_STEP_EN
    .step_req(step_req[2]),
`endif
    .phase_done(phase_done[2]), .flush(flush[2]), .running(run2), .phase(ph2),
    .phase_onehot(oh2), .instr_start(st2), .instr_retire(rt2), .instr_count(cnt2));

  int a_ph[3], a_oh[3], a_cnt[3], a_run[3], a_st[3], a_rt[3];
  always_comb begin
    a_ph[0] = int'(ph0); a_oh[0] = int'(oh0); a_cnt[0] = int'(cnt0);
    a_run[0] = int'(run0); a_st[0] = int'(st0); a_rt[0] = int'(rt0);
    a_ph[1] = int'(ph1); a_oh[1] = int'(oh1); a_cnt[1] = int'(cnt1);
    a_run[1] = int'(run1); a_st[1] = int'(st1); a_rt[1] = int'(rt1);
    a_ph[2] = int'(ph2); a_oh[2] = int'(oh2); a_cnt[2] = int'(cnt2);
    a_run[2] = int'(run2); a_st[2] = int'(st2); a_rt[2] = int'(rt2);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int np(input int k);
    return (k == 0) ? 2 : (k == 1) ? 4 : 3;
  endfunction
  function automatic int cw(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : 8;
  endfunction
  function automatic int sr(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  // Model: mode, phase number and retired count per instance, advanced on each clock edge.
  int m_mode[3], m_ph[3], m_cnt[3], m_st[3], m_rt[3];
  bit started[3];

  function automatic void model_step(input int k);
    int nm;
    bit adv, stp;
    stp = 1'b0;
`ifdef PATP_SEQ_STEP_EN
    stp = step_req[k];
`endif
    m_st[k] = 0;
    m_rt[k] = 0;
    if (rst[k]) begin
      m_mode[k] = (sr(k) != 0) ? M_RUN : M_HALT;
      m_ph[k] = 0;
      m_cnt[k] = 0;
      m_st[k] = sr(k);
      started[k] = 1'b1;
      return;
    end
    if (flush[k]) begin
      if (m_mode[k] == M_RUN) begin
        m_ph[k] = 0;
        m_st[k] = 1;
      end else if (m_mode[k] != M_HALT) begin
        m_ph[k] = 0;
        m_mode[k] = M_HALT;
      end
      return;
    end
    nm = m_mode[k];
    adv = phase_done[k];
    case (m_mode[k])
      M_HALT: begin
        adv = 1'b0;
        if (!halt_req[k] && run_req[k]) begin
          nm = M_RUN;
          m_st[k] = 1;
        end else if (!halt_req[k] && stp) begin
          nm = M_STEP;
          m_st[k] = 1;
        end
      end
      M_RUN: begin
        if (halt_req[k]) begin
          if (m_ph[k] == 0) begin
            nm = M_HALT;
            adv = 1'b0;
          end else begin
            nm = M_DRAIN;
          end
        end
      end
      default: if (run_req[k] && !halt_req[k]) nm = M_RUN;
    endcase
    if (adv) begin
      if (m_ph[k] == np(k) - 1) begin
        m_ph[k] = 0;
        m_rt[k] = 1;
        m_cnt[k] = (m_cnt[k] + 1) % (1 << cw(k));
        if (nm == M_RUN) m_st[k] = 1;
        else nm = M_HALT;
      end else begin
        m_ph[k] = m_ph[k] + 1;
      end
    end
    m_mode[k] = nm;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (started[k]) begin
        chk($sformatf("u%0d.running", k), a_run[k], (m_mode[k] != M_HALT) ? 1 : 0);
        chk($sformatf("u%0d.phase", k), a_ph[k], m_ph[k]);
        chk($sformatf("u%0d.onehot", k), a_oh[k], 1 << m_ph[k]);
        chk($sformatf("u%0d.instr_start", k), a_st[k], m_st[k]);
        chk($sformatf("u%0d.instr_retire", k), a_rt[k], m_rt[k]);
        chk($sformatf("u%0d.instr_count", k), a_cnt[k], m_cnt[k]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  int exp_ph[6] = '{1, 0, 1, 0, 1, 0};
  int rsum;

  initial begin
    rst = 3'b111;
    run_req = '0;
    halt_req = '0;
    phase_done = '0;
    flush = '0;
`ifdef PATP_SEQ_STEP_EN
    step_req = '0;
`endif
    cyc(1);
    chk("t1.u0.running", a_run[0], 0);
    chk("t1.u0.phase", a_ph[0], 0);
    chk("t1.u0.onehot", a_oh[0], 1);
    chk("t1.u0.count", a_cnt[0], 0);
    chk("t1.u0.start", a_st[0], 0);
    chk("t1.u0.retire", a_rt[0], 0);
    chk("t1.u2.running", a_run[2], 1);
    chk("t1.u2.start", a_st[2], 1);
    rst = '0;
    halt_req[2] = 1'b1;
    run_req[0] = 1'b1;
    cyc(1);
    halt_req[2] = 1'b0;
    run_req[0] = 1'b0;
    chk("t1.u2.halted", a_run[2], 0);
    chk("t2.start", a_st[0], 1);
    chk("t2.running", a_run[0], 1);

    // u0: back-to-back fetch/execute.
    phase_done[0] = 1'b1;
    rsum = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk($sformatf("t2.phase%0d", i), a_ph[0], exp_ph[i]);
      rsum += a_rt[0];
    end
    phase_done[0] = 1'b0;
    chk("t2.retires", rsum, 3);
    chk("t2.count", a_cnt[0], 3);

    // u0: simultaneous run/halt at phase 0, then in HALTED.
    run_req[0] = 1'b1; halt_req[0] = 1'b1;
    cyc(1);
    chk("t4.run_halt.running", a_run[0], 0);
    chk("t4.run_halt.count", a_cnt[0], 3);
    cyc(1);
    run_req[0] = 1'b0; halt_req[0] = 1'b0;
    chk("t4.halted_both.running", a_run[0], 0);
    chk("t4.halted_both.start", a_st[0], 0);
    phase_done[0] = 1'b1;
    cyc(1);
    phase_done[0] = 1'b0;
    chk("t4.done_in_halt.phase", a_ph[0], 0);
    flush[0] = 1'b1;
    cyc(1);
    flush[0] = 1'b0;
    chk("t4.flush_halt.running", a_run[0], 0);
    run_req[0] = 1'b1;
    cyc(1);
    run_req[0] = 1'b0;
    phase_done[0] = 1'b1;
    cyc(1);
    phase_done[0] = 1'b0;
    chk("t4.exec.phase", a_ph[0], 1);
    flush[0] = 1'b1;
    cyc(1);
    flush[0] = 1'b0;
    chk("t4.flush.phase", a_ph[0], 0);
    chk("t4.flush.retire", a_rt[0], 0);
    chk("t4.flush.start", a_st[0], 1);
    chk("t4.flush.count", a_cnt[0], 3);
    // u0: drain cancelled by run_req, then drain aborted by flush.
    phase_done[0] = 1'b1;
    cyc(1);
    phase_done[0] = 1'b0; halt_req[0] = 1'b1;
    cyc(1);
    halt_req[0] = 1'b0; run_req[0] = 1'b1;
    chk("t4.drain.running", a_run[0], 1);
    cyc(1);
    run_req[0] = 1'b0; phase_done[0] = 1'b1;
    cyc(1);
    chk("t4.cancel.start", a_st[0], 1);
    chk("t4.cancel.count", a_cnt[0], 4);
    cyc(1);
    phase_done[0] = 1'b0; halt_req[0] = 1'b1;
    cyc(1);
    halt_req[0] = 1'b0; flush[0] = 1'b1;
    cyc(1);
    flush[0] = 1'b0;
    chk("t4.drain_flush.running", a_run[0], 0);
    chk("t4.drain_flush.phase", a_ph[0], 0);
    chk("t4.drain_flush.count", a_cnt[0], 4);

    // u1 (4 phases): halt at phase 2 drains through 3 and 0.
    run_req[1] = 1'b1;
    cyc(1);
    run_req[1] = 1'b0; phase_done[1] = 1'b1;
    cyc(2);
    chk("t3.phase2", a_ph[1], 2);
    phase_done[1] = 1'b0; halt_req[1] = 1'b1;
    cyc(1);
    halt_req[1] = 1'b0; phase_done[1] = 1'b1;
    chk("t3.drain.running", a_run[1], 1);
    chk("t3.drain.phase", a_ph[1], 2);
    cyc(1);
    chk("t3.phase3", a_ph[1], 3);
    cyc(1);
    chk("t3.retire", a_rt[1], 1);
    chk("t3.count", a_cnt[1], 1);
    chk("t3.halted", a_run[1], 0);
    chk("t3.no_start", a_st[1], 0);
    cyc(1);
    chk("t3.held.phase", a_ph[1], 0);
    chk("t3.held.start", a_st[1], 0);
    phase_done[1] = 1'b0;

    // u1 (4-bit count): wrap and flush.
    run_req[1] = 1'b1;
    cyc(1);
    run_req[1] = 1'b0; phase_done[1] = 1'b1;
    cyc(56);
    chk("t5.count15", a_cnt[1], 15);
    cyc(4);
    chk("t5.wrap.count", a_cnt[1], 0);
    chk("t5.wrap.retire", a_rt[1], 1);
    cyc(60);
    chk("t5.after16.count", a_cnt[1], 15);
    cyc(1);
    chk("t5.phase1", a_ph[1], 1);
    phase_done[1] = 1'b0; flush[1] = 1'b1;
    cyc(1);
    flush[1] = 1'b0;
    chk("t5.flush.phase", a_ph[1], 0);
    chk("t5.flush.retire", a_rt[1], 0);
    chk("t5.flush.count", a_cnt[1], 15);
    halt_req[1] = 1'b1;
    cyc(1);
    halt_req[1] = 1'b0;
    chk("t5.halt.running", a_run[1], 0);

`ifdef PATP_SEQ_STEP_EN
    // u2 (3 phases): single step, then step_req ignored while running.
    step_req[2] = 1'b1;
    cyc(1);
    step_req[2] = 1'b0;
    chk("t6.step.start", a_st[2], 1);
    chk("t6.step.running", a_run[2], 1);
    phase_done[2] = 1'b1;
    cyc(2);
    chk("t6.step.phase2", a_ph[2], 2);
    cyc(1);
    chk("t6.step.retire", a_rt[2], 1);
    chk("t6.step.count", a_cnt[2], 1);
    chk("t6.step.halted", a_run[2], 0);
    chk("t6.step.no_start", a_st[2], 0);
    cyc(1);
    phase_done[2] = 1'b0;
    chk("t6.step.held", a_ph[2], 0);
    run_req[2] = 1'b1;
    cyc(1);
    run_req[2] = 1'b0; step_req[2] = 1'b1; phase_done[2] = 1'b1;
    cyc(2);
    step_req[2] = 1'b0;
    chk("t6.run.phase2", a_ph[2], 2);
    cyc(1);
    chk("t6.run.start", a_st[2], 1);
    chk("t6.run.running", a_run[2], 1);
    chk("t6.run.count", a_cnt[2], 2);
`else
    // u2 (3 phases): one instruction in RUN.
    run_req[2] = 1'b1;
    cyc(1);
    run_req[2] = 1'b0; phase_done[2] = 1'b1;
    cyc(3);
    chk("t6.run.retire", a_rt[2], 1);
    chk("t6.run.start", a_st[2], 1);
    chk("t6.run.count", a_cnt[2], 1);
`endif
    phase_done[2] = 1'b0; halt_req[2] = 1'b1;
    cyc(1);
    halt_req[2] = 1'b0;
    chk("t6.halt.running", a_run[2], 0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
